// File: rtl/demux16_reg_if.sv
// Handshake and channel bus between the ALU result source and the registered 1-to-16 demux.
interface demux16_reg_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [3:0]           sel;
  logic                 bcast;
  logic                 clr;
  logic [NCH*WIDTH-1:0] out_bus;
  logic [NCH-1:0]       out_valid;
  logic                 busy;

  modport master (
    output in_valid, in_data, sel, bcast, clr,
    input  in_ready, out_bus, out_valid, busy
  );

  modport slave (
    input  in_valid, in_data, sel, bcast, clr,
    output in_ready, out_bus, out_valid, busy
  );
endinterface

// File: rtl/demux16_reg.sv
// Registered 1-to-16 demultiplexer: routes one result to a held channel register,
// or sweeps a captured value across all 16 channels one per cycle.
module demux16_reg #(
  parameter int WIDTH = 8,
  parameter int NCH   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  demux16_reg_if.slave   bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [3:0]                 cnt_q,   cnt_d;
  logic [4:0]                 len_q,   len_d;
  logic [WIDTH-1:0]           data_q,  data_d;
  logic [NCH-1:0][WIDTH-1:0]  chan_q,  chan_d;
  logic [NCH-1:0]             valid_q, valid_d;

  assign bus.in_ready  = (state_q == IDLE) && !bus.clr;
  assign bus.busy      = (state_q == SWEEP);
  assign bus.out_bus   = chan_q;
  assign bus.out_valid = valid_q;

  // clr outranks both a fresh accept and an in-flight sweep write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = '0;
    if (bus.clr) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      len_d   = 5'd0;
      chan_d  = '0;
    end else if (state_q == IDLE) begin
      if (bus.in_valid) begin
        if (bus.bcast) begin
          data_d  = bus.in_data;
          cnt_d   = bus.sel;
          len_d   = 5'd0;
          state_d = SWEEP;
        end else begin
          chan_d[bus.sel]  = bus.in_data;
          valid_d[bus.sel] = 1'b1;
        end
      end
    end else begin
      chan_d[cnt_q]  = data_q;
      valid_d[cnt_q] = 1'b1;
      cnt_d          = cnt_q + 4'd1;
      len_d          = len_q + 5'd1;
      // len_q counts completed writes; 15 here means this edge is the 16th.
      if (len_q == 5'd15) begin
        state_d = IDLE;
        len_d   = 5'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      len_q   <= 5'd0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_demux16_reg.sv
// Directed bench for demux16_reg: single writes, broadcast sweeps, clr abort,
// asynchronous reset mid-sweep and back-to-back writes to one channel.
module tb_demux16_reg;

  logic clk;
  logic rst_n;
  logic [127:0] expBus;
  int checkCount;
  int errorCount;

  demux16_reg_if #(.WIDTH(8), .NCH(16)) dutIf ();

  demux16_reg #(.WIDTH(8), .NCH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dutIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] sel,
                               input logic [7:0] data, input logic bcast);
    dutIf.in_valid = valid;
    dutIf.sel      = sel;
    dutIf.in_data  = data;
    dutIf.bcast    = bcast;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    expBus     = '0;
    rst_n      = 1'b0;
    dutIf.clr  = 1'b0;
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);

    #2;
    checkOutput("reset_bus",   dutIf.out_bus,   128'd0);
    checkOutput("reset_valid", dutIf.out_valid, 128'd0);
    checkOutput("reset_busy",  dutIf.busy,      128'd0);
    checkOutput("reset_ready", dutIf.in_ready,  128'd1);
    step();
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      logic [7:0] v;
      v = (k == 0) ? 8'd23 : 8'(k + 1);
      applyStimulus(1'b1, 4'(k), v, 1'b0);
      step();
      expBus[k*8 +: 8] = v;
      checkOutput($sformatf("single_valid_%0d", k), dutIf.out_valid, 128'(16'b1 << k));
      checkOutput($sformatf("single_bus_%0d", k),   dutIf.out_bus,   expBus);
      checkOutput($sformatf("single_ready_%0d", k), dutIf.in_ready,  128'd1);
    end
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
    step();
    checkOutput("idle_valid", dutIf.out_valid, 128'd0);
    checkOutput("idle_bus",   dutIf.out_bus,   expBus);

    applyStimulus(1'b1, 4'hA, 8'h5C, 1'b1);
    step();
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
    checkOutput("bc1_accept_busy",  dutIf.busy,      128'd1);
    checkOutput("bc1_accept_ready", dutIf.in_ready,  128'd0);
    checkOutput("bc1_accept_valid", dutIf.out_valid, 128'd0);
    checkOutput("bc1_accept_bus",   dutIf.out_bus,   expBus);
    for (int i = 0; i < 16; i++) begin
      int k;
      k = (10 + i) % 16;
      step();
      expBus[k*8 +: 8] = 8'h5C;
      checkOutput($sformatf("bc1_valid_%0d", i), dutIf.out_valid, 128'(16'b1 << k));
      checkOutput($sformatf("bc1_bus_%0d", i),   dutIf.out_bus,   expBus);
      checkOutput($sformatf("bc1_busy_%0d", i),  dutIf.busy,      (i < 15) ? 128'd1 : 128'd0);
      checkOutput($sformatf("bc1_ready_%0d", i), dutIf.in_ready,  (i == 15) ? 128'd1 : 128'd0);
    end
    checkOutput("bc1_all_5c", dutIf.out_bus, {16{8'h5C}});

    applyStimulus(1'b1, 4'd3, 8'h11, 1'b1);
    step();
    applyStimulus(1'b1, 4'd9, 8'h77, 1'b0);
    for (int i = 0; i < 16; i++) begin
      int k;
      k = (3 + i) % 16;
      step();
      expBus[k*8 +: 8] = 8'h11;
      checkOutput($sformatf("bc2_valid_%0d", i), dutIf.out_valid, 128'(16'b1 << k));
      checkOutput($sformatf("bc2_bus_%0d", i),   dutIf.out_bus,   expBus);
    end
    step();
    expBus[9*8 +: 8] = 8'h77;
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
    checkOutput("bc2_after_valid", dutIf.out_valid, 128'(16'b1 << 9));
    checkOutput("bc2_after_bus",   dutIf.out_bus,   expBus);

    applyStimulus(1'b1, 4'd0, 8'h42, 1'b1);
    step();
    applyStimulus(1'b1, 4'd2, 8'hAB, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      expBus[i*8 +: 8] = 8'h42;
      checkOutput($sformatf("clr_pre_bus_%0d", i), dutIf.out_bus, expBus);
    end
    dutIf.clr = 1'b1;
    step();
    expBus = '0;
    checkOutput("clr_bus",   dutIf.out_bus,   expBus);
    checkOutput("clr_busy",  dutIf.busy,      128'd0);
    checkOutput("clr_valid", dutIf.out_valid, 128'd0);
    checkOutput("clr_ready", dutIf.in_ready,  128'd0);
    dutIf.clr = 1'b0;
    #1;
    checkOutput("clr_ready_after", dutIf.in_ready, 128'd1);
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
    step();
    checkOutput("clr_hold_bus", dutIf.out_bus, expBus);

    applyStimulus(1'b1, 4'd6, 8'h3C, 1'b1);
    step();
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
    step();
    step();
    checkOutput("rst_pre_busy", dutIf.busy, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_bus",   dutIf.out_bus,   128'd0);
    checkOutput("rst_mid_valid", dutIf.out_valid, 128'd0);
    checkOutput("rst_mid_busy",  dutIf.busy,      128'd0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'd3, 8'd99, 1'b0);
    step();
    expBus = '0;
    expBus[3*8 +: 8] = 8'd99;
    checkOutput("rst_write_bus",   dutIf.out_bus,   expBus);
    checkOutput("rst_write_valid", dutIf.out_valid, 128'(16'b1 << 3));

    for (int v = 1; v <= 3; v++) begin
      applyStimulus(1'b1, 4'd7, 8'(v), 1'b0);
      step();
      expBus[7*8 +: 8] = 8'(v);
      checkOutput($sformatf("b2b_ch7_%0d", v),   dutIf.out_bus[7*8 +: 8], 128'(v));
      checkOutput($sformatf("b2b_valid_%0d", v), dutIf.out_valid,         128'(16'b1 << 7));
    end
    applyStimulus(1'b0, 4'd0, 8'd0, 1'b0);
    step();
    checkOutput("b2b_end_valid", dutIf.out_valid, 128'd0);
    checkOutput("b2b_end_bus",   dutIf.out_bus,   expBus);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/demux16_reg.md
Name: demux16_reg

Overview:
- Registered 1-to-16 demultiplexer with valid/ready input handshake. It is the distribution-side counterpart of the 16-to-1 8-bit selector in the ALU datapath.
- Routes one 8-bit result to one of 16 held channel registers selected by a 4-bit code. Optionally broadcasts one value to all 16 channels, one channel per cycle.
- Sits between the ALU result bus and the 16 operand/result holding slots that feed the selector.

Parameters:
- WIDTH, 8, data width of each channel.
- NCH, 16, number of channels; fixed at 16 (select width 4). Other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  source presents a transfer
- in_ready  output  1  block accepts a transfer this cycle
- in_data  input  WIDTH  value to route
- sel  input  4  destination channel (0..15); start channel in broadcast
- bcast  input  1  when 1 with an accepted transfer, write in_data to all 16 channels
- clr  input  1  synchronous clear of all channels
- out_bus  output  NCH*WIDTH  channel k held at bits [WIDTH*k+WIDTH-1 : WIDTH*k]
- out_valid  output  NCH  bit k pulses high for exactly the cycle after channel k is written
- busy  output  1  high while a broadcast sweep is in progress

Behaviour:
- Reset (rst_n low, asynchronous): out_bus = 0, out_valid = 0, busy = 0, state IDLE, sweep counter = 0, captured data = 0.
- in_ready is combinational: in_ready = (state == IDLE) && !clr. It is therefore 1 while rst_n is low and clr is low.
- Accept condition: in_valid && in_ready at a rising edge. in_data, sel and bcast are ignored whenever in_ready is 0.
- IDLE, accept with bcast = 0: at that edge channel sel <= in_data and out_valid = one-hot(sel) for the following cycle. Other channels hold. Remain in IDLE. Latency is 1 cycle and throughput is 1 transfer per cycle; back-to-back accepts to the same or different channels are legal.
- IDLE, accept with bcast = 1: at that edge capture in_data, load cnt = sel, and enter SWEEP. No channel is written on the accepting edge.
- SWEEP: on each edge, channel cnt <= captured data and out_valid = one-hot(cnt) for the next cycle; then cnt <= cnt + 1 mod 16.
  - Exactly 16 writes occur: sel, sel+1, ..., 15, 0, ..., sel-1 (wrap 15 -> 0).
  - After the 16th write, return to IDLE.
  - busy = 1 and in_ready = 0 for all 16 sweep cycles. in_ready returns to 1 in the cycle after the last write edge.
- out_valid is 0 in any cycle not following a write. At most one bit is set at a time.
- clr = 1 at an edge, in any state:
  - all channels <= 0, out_valid <= 0, state <= IDLE, busy <= 0, cnt <= 0.
  - Any in-progress sweep is aborted.
  - clr has priority over accept and sweep writes; no transfer is accepted that cycle.
- rst_n asserted mid-sweep: immediate abort to the reset values above. After release, the first edge with a valid accept behaves as from IDLE.
- Channel registers hold their values indefinitely until written, cleared, or reset.
- No arithmetic on data. cnt is 4 bits and wraps naturally. A separate 5-bit or equivalent sweep-length counter terminates the sweep after exactly 16 writes.

Test Plan:
- Reset then single writes: sel = 0..15 with in_data = 23, 2, 3, ..., 16, one per cycle, in_valid held 1 -> channel k holds its value one cycle after the accept; out_valid = one-hot(k) each cycle; in_ready stays 1; all other channels keep their prior values.
- Broadcast from sel = 4'hA, in_data = 8'h5C -> busy high for 16 cycles; writes in order A, B, C, D, E, F, 0, ..., 9; all 16 channels = 8'h5C at the end; in_ready = 0 for 16 cycles, then 1.
- Broadcast with in_valid held high and new data during the sweep -> in_ready = 0 and no extra writes occur; the next transfer is accepted on the first edge after the sweep ends and lands 1 cycle later.
- clr asserted on sweep cycle 5 with in_valid = 1 -> all channels 0 the next cycle, busy = 0, out_valid = 0, the input is not accepted; in_ready = 1 once clr drops.
- rst_n pulsed low mid-sweep (asynchronous, between edges) -> out_bus = 0, out_valid = 0, busy = 0 immediately. A write of 8'd99 to sel = 3 after release -> only channel 3 = 99.
- Back-to-back writes to the same channel 7 (values 1, 2, 3) -> channel 7 reads 1, 2, 3 on successive cycles; out_valid[7] is high for three consecutive cycles.
